// File: rtl/fpu_pkg.sv
// Shared FP32 constants and helpers for the FP multiply datapath.
// Also holds the fmul core latency constant.
package fpu_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FMUL_LAT = 2;

    typedef logic [FP_W-1:0] fp32_t;

    function automatic logic fp_is_zero(input fp32_t x);
        return x[FP_W-2:0] == '0;
    endfunction

    function automatic logic fp_exp_zero(input fp32_t x);
        return x[FP_W-2:FP_MAN_W] == '0;
    endfunction

endpackage

// File: rtl/fmul_result_fifo.sv
// In-order result FIFO with a registered head entry.
// Ring storage sits behind the head register; a push into an empty FIFO lands directly in the head.
module fmul_result_fifo
    import fpu_pkg::*;
#(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             head_valid;
    logic [W-1:0]     head_data;
    logic             pop;
    logic             head_free;
    logic             load_mem;
    logic             load_direct;
    logic             mem_push;

    assign pop         = head_valid && rd_ready;
    assign head_free   = !head_valid || pop;
    assign load_mem    = head_free && (count != '0);
    assign load_direct = head_free && (count == '0) && wr_en;
    assign mem_push    = wr_en && !load_direct;

    assign rd_valid = head_valid;
    assign rd_data  = head_data;

    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head refills from storage first so older entries always leave first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (mem_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load_mem) begin
                head_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
            end else if (load_direct) begin
                head_data <= wr_data;
            end
            if (head_free) begin
                head_valid <= load_mem || load_direct;
            end
            count <= count + (PTR_W+1)'(mem_push) - (PTR_W+1)'(load_mem);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
        !(mem_push && count == (PTR_W+1)'(DEPTH)));

endmodule

// File: rtl/fmul_issue.sv
// Issue/writeback controller around the 2-stage fmul core: credit-based intake, tag tracking, result queue.
// Optional FMUL_ISSUE_ZERO_BYPASS_EN forces signed-zero results for zero operands.
module fmul_issue
    import fpu_pkg::*;
#(
    parameter int TAG_W  = 6,
    parameter int LAT    = FMUL_LAT,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fmul_x1,
    output logic [31:0]      fmul_x2,
    input  logic [31:0]      fmul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int ENT_W = FP_W + TAG_W;

    logic             accept;
    logic             pop;
    logic             swap;
    logic [CNT_W-1:0] cnt;
    logic [LAT-1:0]   pipe_valid;
    logic [TAG_W-1:0] pipe_tag [LAT];
    logic [FP_W-1:0]  cap_y;
    logic [ENT_W-1:0] head;

    // fmul needs a normal x1, so a denormal/zero x1 trades places with a normal x2.
    always_comb begin
        swap    = fp_exp_zero(in_x1) && !fp_exp_zero(in_x2);
        fmul_x1 = swap ? in_x2 : in_x1;
        fmul_x2 = swap ? in_x1 : in_x2;
    end

    assign in_ready = cnt < CNT_W'(QDEPTH);
    assign busy     = cnt != '0;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!accept && pop) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_tag[0]   <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

`ifdef FMUL_ISSUE_ZERO_BYPASS_EN
    logic [LAT-1:0] pipe_zero;
    logic [LAT-1:0] pipe_zsign;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_zero  <= '0;
            pipe_zsign <= '0;
        end else begin
            pipe_zero[0]  <= fp_is_zero(in_x1) || fp_is_zero(in_x2);
            pipe_zsign[0] <= in_x1[FP_W-1] ^ in_x2[FP_W-1];
            for (int i = 1; i < LAT; i++) begin
                pipe_zero[i]  <= pipe_zero[i-1];
                pipe_zsign[i] <= pipe_zsign[i-1];
            end
        end
    end

    assign cap_y = pipe_zero[LAT-1] ? {pipe_zsign[LAT-1], {(FP_W-1){1'b0}}} : fmul_y;
`else
    assign cap_y = fmul_y;
`endif

    // The credit counter bounds in-flight plus queued entries, so the queue never sees a push it cannot hold.
    fmul_result_fifo #(
        .W     (ENT_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (pipe_valid[LAT-1]),
        .wr_data  ({pipe_tag[LAT-1], cap_y}),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (head)
    );

    assign {out_tag, out_y} = head;

endmodule

// File: tb/tb_fmul_issue.sv
// Scoreboard bench for fmul_issue with a table-driven stand-in for the 2-stage fmul core.
module tb_fmul_issue;

    localparam int TAG_W = 6;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fmul_x1;
    logic [31:0]      fmul_x2;
    logic [31:0]      fmul_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef struct {
        logic [31:0] y;
        logic [31:0] tag;
        bit          check_y;
        int          exp_cycle;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   tests_run = 0;
    int   fails     = 0;
    int   cyc       = 0;

    logic [31:0] str_x1 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] str_y  [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    fmul_issue #(.TAG_W(TAG_W), .LAT(2), .QDEPTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .fmul_x1   (fmul_x1),
        .fmul_x2   (fmul_x2),
        .fmul_y    (fmul_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in fmul: products for the operand pairs used here; the zero case drops the sign like a naive core.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h40000000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h40000000}: return 32'h40C00000;
            {32'h40800000, 32'h40000000}: return 32'h41000000;
            {32'h40A00000, 32'h40000000}: return 32'h41200000;
            {32'h40C00000, 32'h40000000}: return 32'h41400000;
            {32'h40E00000, 32'h40000000}: return 32'h41600000;
            {32'h41000000, 32'h40000000}: return 32'h41800000;
            {32'h40000000, 32'h00400000}: return 32'h00800000;
            {32'h3F800000, 32'h80000000}: return 32'h00000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic [31:0] fmul_s1;
    always @(posedge clk) begin
        fmul_s1 <= fmul_ref(fmul_x1, fmul_x2);
        fmul_y  <= fmul_s1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int t);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cyc >= t) return;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] x1, input logic [31:0] x2, input logic [TAG_W-1:0] tag,
                                 input logic [31:0] exp_y, input bit check_y, input bit push_sb,
                                 input bit stream_chk, output int acc_cycle);
        exp_t e;
        in_valid = 1'b1;
        in_x1    = x1;
        in_x2    = x2;
        in_tag   = tag;
        acc_cycle = -1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (stream_chk && w == 0) checkOutput("stream_in_ready", {31'b0, in_ready}, 32'd1);
            if (in_ready) begin
                acc_cycle   = cyc;
                e.y         = exp_y;
                e.tag       = {26'b0, tag};
                e.check_y   = check_y;
                e.exp_cycle = cyc + 3;
                if (push_sb) sb.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        fails++;
        $display("[TB] FAIL accept_timeout: got in_ready 0 for 50 cycles, expected 1");
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                fails++;
                $display("[TB] FAIL unexpected_result: got tag %0d y 0x%08h, expected none", out_tag, out_y);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("out_tag", {26'b0, out_tag}, mon_e.tag);
                if (mon_e.check_y) checkOutput("out_y", out_y, mon_e.y);
                if (mon_e.exp_cycle >= 0) checkOutput("out_cycle", cyc, mon_e.exp_cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by 100000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int n_acc;
        int idx;
        bit zchk;
        logic [31:0] zexp;
        exp_t e;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_x1     = '0;
        in_x2     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_y", out_y, 32'h0);
        checkOutput("rst_out_tag", {26'b0, out_tag}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single op, operands passed straight through.
        in_x1 = 32'h3FC00000;
        in_x2 = 32'h40000000;
        #1;
        checkOutput("pass_x1", fmul_x1, 32'h3FC00000);
        checkOutput("pass_x2", fmul_x2, 32'h40000000);
        applyStimulus(32'h3FC00000, 32'h40000000, 6'd5, 32'h40400000, 1, 1, 0, acc);
        in_valid = 1'b0;
        wait_neg(acc + 3);
        checkOutput("busy_c3", {31'b0, busy}, 32'd1);
        wait_neg(acc + 4);
        checkOutput("busy_c4", {31'b0, busy}, 32'd0);

        // Streaming: eight back-to-back requests.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(str_x1[i], 32'h40000000, TAG_W'(i), str_y[i], 1, 1, 1, acc);
        end
        in_valid = 1'b0;
        wait_neg(acc + 5);

        // Denormal x1 is swapped behind a normal x2.
        @(posedge clk);
        #1;
        in_x1 = 32'h00400000;
        in_x2 = 32'h40000000;
        #1;
        checkOutput("swap_x1", fmul_x1, 32'h40000000);
        checkOutput("swap_x2", fmul_x2, 32'h00400000);
        applyStimulus(32'h00400000, 32'h40000000, 6'd9, 32'h00800000, 1, 1, 0, acc);
        in_valid = 1'b0;
        wait_neg(acc + 5);

        // Signed zero operand.
`ifdef FMUL_ISSUE_ZERO_BYPASS_EN
        zchk = 1'b1;
        zexp = 32'h80000000;
`else
        zchk = 1'b0;
        zexp = 32'h0;
`endif
        @(posedge clk);
        #1;
        applyStimulus(32'h80000000, 32'h3F800000, 6'd33, zexp, zchk, 1, 0, acc);
        in_valid = 1'b0;
        wait_neg(acc + 5);

        // Backpressure: hold the output and keep requesting.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_acc     = 0;
        idx       = 0;
        in_valid  = 1'b1;
        in_x1     = str_x1[0];
        in_x2     = 32'h40000000;
        in_tag    = 6'd10;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) begin
                checkOutput("bp_hold_y", out_y, 32'h40000000);
                checkOutput("bp_hold_tag", {26'b0, out_tag}, 32'd10);
            end
            if (in_ready) begin
                e.y         = str_y[idx];
                e.tag       = 32'(10 + idx);
                e.check_y   = 1'b1;
                e.exp_cycle = -1;
                sb.push_back(e);
                n_acc++;
                if (idx < 7) idx++;
            end
            @(posedge clk);
            #1;
            in_x1  = str_x1[idx];
            in_tag = TAG_W'(10 + idx);
        end
        checkOutput("bp_accepts", n_acc, 32'd4);
        checkOutput("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_pop_cycle", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("bp_in_ready_after_pop", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);

        // Reset with three requests in flight.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(str_x1[i], 32'h40000000, TAG_W'(20 + i), str_y[i], 1, 0, 0, acc);
        end
        in_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_out", {31'b0, out_valid}, 32'd0);
        end

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fmul_issue.md
# fmul_issue

Issue/writeback controller that sits directly upstream and downstream of the 2-stage `fmul` core. It accepts multiply requests over a valid/ready handshake, conditions the operands, and drives them into `fmul`. It tracks each in-flight product with a destination tag and captures results into a small in-order queue, so the non-stallable multiplier can live behind a back-pressured writeback port.

## Interface
- `TAG_W`, 6: width of the destination-register tag.
- `LAT`, 2: `fmul` latency in clock edges, counted from the operand-sample edge to the edge that registers `y`.
- `QDEPTH`, 4: result-queue depth. Must be a power of 2 and ≥ LAT+1.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_x1` in 32: FP32 operand.
- `in_x2` in 32: FP32 operand.
- `in_tag` in TAG_W: destination tag.
- `fmul_x1` out 32: conditioned operand to `fmul` x1.
- `fmul_x2` out 32: conditioned operand to `fmul` x2.
- `fmul_y` in 32: `fmul` result. Its `ovf` output is ignored.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_y` out 32: FP32 product.
- `out_tag` out TAG_W: tag of `out_y`.
- `busy` out 1: any request in flight or queued.

## Operation
- Operand conditioning is combinational from `in_x1`/`in_x2`.
  - `fmul` requires x1 normal. If `in_x1[30:23]==0` and `in_x2[30:23]!=0`, swap the operands. Otherwise pass them straight through.
  - `fmul_x1`/`fmul_x2` are driven every cycle regardless of `in_valid`.
- Credit counter `cnt` (0..QDEPTH) counts in-flight plus queued entries.
  - Accept adds 1; pop subtracts 1; accept and pop in the same cycle leave it unchanged.
  - `in_ready = (cnt < QDEPTH)`, taken from registers only. It never depends on `in_valid`.
- Tracking pipeline: LAT stages of {valid, tag, zero, zsign}.
  - Stage 0 loads on the accept edge. Non-accept edges load valid=0.
  - Stages shift every cycle. The pipeline never stalls.
- Capture: when the last stage is valid, `fmul_y` holds that request's product. Write it, with its tag, into the queue on the next edge.
- Queue: in-order FIFO of QDEPTH entries. `out_y`/`out_tag`/`out_valid` come from the head register.
  - Overflow is impossible by construction of the credit counter. An overflow in simulation is an assertion failure.
- Inf/NaN inputs are not special-cased. They pass through `fmul` unmodified.
- `busy = (cnt != 0)`.

## Timing
- Request accepted in cycle 0 → `out_valid` high in cycle LAT+1 (cycle 3 by default), provided no older result is blocking.
- Full throughput is one result per cycle with `out_ready` held 1.
- `out_ready=0` holds `out_y`/`out_tag` stable. `in_ready` falls once `cnt` reaches QDEPTH and rises the cycle after the first pop.
- Push and pop in the same cycle on a non-empty queue: both take effect. Order is preserved.
- Push into an empty queue: `out_valid` rises the next cycle. There is no combinational bypass from `fmul_y`.
- Reset values:
  - `in_ready`=1 (QDEPTH>0).
  - `out_valid`=0, `out_y`=0, `out_tag`=0, `busy`=0.
  - Every tracking-pipeline valid bit is 0 and `cnt`=0.
- Reset mid-operation discards all in-flight and queued requests. `fmul` has no reset; its stale `y` is ignored because the tracking valids are cleared.

## Configuration
- `FMUL_ISSUE_ZERO_BYPASS_EN` defined:
  - At accept, record zero = (`in_x1[30:0]==0 || in_x2[30:0]==0`) and zsign = `in_x1[31]^in_x2[31]`.
  - At capture, zero entries write {zsign, 31'b0} in place of `fmul_y`.
  - Latency is unchanged.
- Not defined: no zero/zsign state. `fmul_y` is always written, and zero operands yield whatever `fmul` produces.

## Structure
- Shared package `fpu_pkg` holds:
  - FP32 field constants: `FP_EXP_W`=8, `FP_MAN_W`=23.
  - Helper functions `fp_is_zero` and `fp_exp_zero`.
  - The `fmul` latency constant, which provides LAT's default.
- One sub-module, `fmul_result_fifo`, parameterised by width and depth. It uses head/tail pointers of $clog2(QDEPTH) bits that wrap, plus a count, and has a registered head output.

## Test plan
- Single op: `in_x1`=0x3FC00000, `in_x2`=0x40000000, tag 5, `out_ready`=1 → cycle 3: `out_valid`=1, `out_y`=0x40400000, `out_tag`=5; `busy` falls in cycle 4.
- Streaming: 8 back-to-back ops, tags 0..7, `out_ready`=1 → `in_ready` never drops; results appear in cycles 3..10 in tag order.
- Backpressure: `out_ready`=0 with continuous requests → exactly 4 accepts, then `in_ready`=0 and `out_y` stable. Set `out_ready`=1 → 4 in-order results; `in_ready` is back to 1 one cycle after the first pop.
- Swap: `in_x1`=0x00400000, `in_x2`=0x40000000 → `fmul_x1`=0x40000000, `fmul_x2`=0x00400000; `out_y`=0x00800000.
- Zero bypass (macro defined): `in_x1`=0x80000000, `in_x2`=0x3F800000 → `out_y`=0x80000000 in cycle 3. With the macro undefined, check only timing and tag.
- Reset mid-flight: 3 ops accepted, then `rstn` low for one cycle → `out_valid`=0, `busy`=0, `in_ready`=1; no results emerge within 10 cycles after release.
